// File: rtl/throw_force_meter_if.sv
// Signal bundle between the throw force meter and its surroundings.
// The meter side uses the slave modport; the driver of button/turn/hit
// inputs (and consumer of the meter outputs) uses the master modport.
interface throw_force_meter_if;
  logic       btn;
  logic       turn_active;
  logic       hit_dog;
  logic [9:0] throw_force;
  logic       enable;
  logic       charging;
  logic       ready;

  modport master (
    output btn,
    output turn_active,
    output hit_dog,
    input  throw_force,
    input  enable,
    input  charging,
    input  ready
  );

  modport slave (
    input  btn,
    input  turn_active,
    input  hit_dog,
    output throw_force,
    output enable,
    output charging,
    output ready
  );
endinterface

// File: rtl/throw_force_meter.sv
// Throw force meter: while the button is held the force ramps up and down
// between 0 and FORCE_MAX once per meter tick; releasing the button latches
// the force and holds enable for HOLD_TICKS ticks (or until a hit), then a
// short cooldown precedes re-arming.
module throw_force_meter #(
  parameter int unsigned TICK_DIV        = 65000,
  parameter int unsigned FORCE_STEP      = 10,
  parameter int unsigned FORCE_MAX       = 1000,
  parameter int unsigned HOLD_TICKS      = 3000,
  parameter int unsigned COOLDOWN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  throw_force_meter_if.slave   bus
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int unsigned CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN_CYCLES - 1);

  localparam logic [10:0] STEP11 = 11'(FORCE_STEP);
  localparam logic [10:0] MAX11  = 11'(FORCE_MAX);
  localparam logic [9:0]  STEP10 = 10'(FORCE_STEP);
  localparam logic [9:0]  MAX10  = 10'(FORCE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHARGE   = 2'd1,
    THROW    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t          state;
  logic            btn_m;
  logic            btn_s;
  logic            btn_d;
  logic            press;
  logic            release_evt;
  logic [TW-1:0]   tick_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [CW-1:0]   cd_cnt;
  logic            tick;
  logic            dir_up;
  logic [9:0]      force_q;
  logic            enable_q;
  logic            charging_q;
  logic            ready_q;

  logic [10:0]     force_w;
  logic [10:0]     up_sum;
  logic [9:0]      ramp_force;
  logic            ramp_up;

  assign bus.throw_force = force_q;
  assign bus.enable      = enable_q;
  assign bus.charging    = charging_q;
  assign bus.ready       = ready_q;

  // Two-flop synchronizer for the raw button plus one delay stage for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      btn_d <= 1'b0;
    end else begin
      btn_m <= bus.btn;
      btn_s <= btn_m;
      btn_d <= btn_s;
    end
  end

  assign press       = btn_s & ~btn_d;
  assign release_evt = ~btn_s & btn_d;
  assign tick        = (tick_cnt == TICK_LAST);

  // Next ramp value; 11-bit sum so a step past the ceiling cannot wrap.
  always_comb begin
    force_w    = {1'b0, force_q};
    up_sum     = force_w + STEP11;
    ramp_force = force_q;
    ramp_up    = dir_up;
    if (dir_up) begin
      if (up_sum >= MAX11) begin
        ramp_force = MAX10;
        ramp_up    = 1'b0;
      end else begin
        ramp_force = up_sum[9:0];
      end
    end else begin
      if (force_w <= STEP11) begin
        ramp_force = '0;
        ramp_up    = 1'b1;
      end else begin
        ramp_force = force_q - STEP10;
      end
    end
  end

  // Main state machine with registered outputs. Priority in CHARGE is
  // turn loss, then release (so release beats a same-cycle tick), then tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      force_q    <= '0;
      enable_q   <= 1'b0;
      charging_q <= 1'b0;
      ready_q    <= 1'b0;
      tick_cnt   <= '0;
      hold_cnt   <= '0;
      cd_cnt     <= '0;
      dir_up     <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          force_q    <= '0;
          enable_q   <= 1'b0;
          charging_q <= 1'b0;
          if (press && bus.turn_active) begin
            state      <= CHARGE;
            charging_q <= 1'b1;
            tick_cnt   <= '0;
            dir_up     <= 1'b1;
          end else begin
            ready_q <= bus.turn_active;
          end
        end

        CHARGE: begin
          if (!bus.turn_active) begin
            state      <= IDLE;
            force_q    <= '0;
            charging_q <= 1'b0;
            tick_cnt   <= '0;
            dir_up     <= 1'b1;
          end else if (release_evt) begin
            state      <= THROW;
            charging_q <= 1'b0;
            enable_q   <= 1'b1;
            tick_cnt   <= '0;
            hold_cnt   <= '0;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
              force_q <= ramp_force;
              dir_up  <= ramp_up;
            end
          end
        end

        THROW: begin
          if (bus.hit_dog || (tick && (hold_cnt == HOLD_LAST))) begin
            state    <= COOLDOWN;
            enable_q <= 1'b0;
            cd_cnt   <= '0;
            tick_cnt <= '0;
            hold_cnt <= '0;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end

        COOLDOWN: begin
          enable_q <= 1'b0;
          if (cd_cnt == CD_LAST) begin
            state   <= IDLE;
            force_q <= '0;
            cd_cnt  <= '0;
            dir_up  <= 1'b1;
            ready_q <= bus.turn_active;
          end else begin
            cd_cnt <= cd_cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_throw_force_meter.sv
// Bench for throw_force_meter with small parameters. A behavioural model
// tracks the phase and the time spent in it, derives the ramp value from a
// triangle-wave formula, and is compared with the outputs every cycle.
module tb_throw_force_meter;

  localparam int TD   = 4;
  localparam int STEP = 10;
  localparam int FMAX = 50;
  localparam int HOLD = 20;
  localparam int CD   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  throw_force_meter_if bus ();

  throw_force_meter #(
    .TICK_DIV        (TD),
    .FORCE_STEP      (STEP),
    .FORCE_MAX       (FMAX),
    .HOLD_TICKS      (HOLD),
    .COOLDOWN_CYCLES (CD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 charging, 2 throwing, 3 cooldown; age = cycles in phase
  int   m_ph    = 0;
  int   m_age   = 0;
  int   m_latch = 0;
  int   m_nph   = 0;
  logic m_ready = 1'b0;
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;
  logic m_pr, m_rl;

  // Force after n ticks: triangle wave 0..FMAX..0 in steps of STEP.
  function automatic int tri_wave(input int n);
    int period;
    int p;
    period = 2 * FMAX / STEP;
    p = n % period;
    return (p <= FMAX / STEP) ? p * STEP : (period - p) * STEP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_age = 0; m_latch = 0; m_ready = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
    end else begin
      m_pr  = m_s2 & ~m_s3;
      m_rl  = ~m_s2 & m_s3;
      m_nph = m_ph;
      case (m_ph)
        0: if (m_pr && bus.turn_active) m_nph = 1;
        1: begin
          if (!bus.turn_active) m_nph = 0;
          else if (m_rl) begin
            m_nph = 2;
            m_latch = tri_wave(m_age / TD);
          end
        end
        2: if (bus.hit_dog || (m_age + 1 == HOLD * TD)) m_nph = 3;
        default: if (m_age + 1 == CD) m_nph = 0;
      endcase
      m_age   = (m_nph != m_ph) ? 0 : m_age + 1;
      m_ph    = m_nph;
      m_ready = (m_nph == 0) && bus.turn_active;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = bus.btn;
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    chk("force", int'(bus.throw_force),
        (m_ph == 1) ? tri_wave(m_age / TD) : ((m_ph >= 2) ? m_latch : 0));
    chk("enable",   int'(bus.enable),   int'(m_ph == 2));
    chk("charging", int'(bus.charging), int'(m_ph == 1));
    chk("ready",    int'(bus.ready),    int'(m_ready));
  end

  // ---------------- stimulus ----------------
  int exp_seq[$];
  int seen[$];

  // Hold the button k cycles, record distinct charge values, and check that
  // enable comes up with the latched force.
  task automatic press_hold(input int k, input int latch_exp, input string nm);
    int last;
    last = 0;
    seen.delete();
    bus.btn = 1'b1;
    for (int j = 0; j < k + 2; j++) begin
      if (j == k) bus.btn = 1'b0;
      @(negedge clk);
      if (bus.charging && int'(bus.throw_force) != last) begin
        last = int'(bus.throw_force);
        seen.push_back(last);
      end
    end
    @(negedge clk);
    chk({nm, "_seq_len"}, seen.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < seen.size(); i++)
      chk({nm, "_seq"}, seen[i], exp_seq[i]);
    chk({nm, "_enable"}, int'(bus.enable), 1);
    chk({nm, "_latched"}, int'(bus.throw_force), latch_exp);
  endtask

  task automatic wait_idle(input string nm);
    int cnt;
    cnt = 0;
    while ((bus.enable || bus.charging || bus.throw_force != 0) && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk({nm, "_idle_in_time"}, int'(cnt < 300), 1);
  endtask

  initial begin
    int cnt;
    bus.btn = 1'b0;
    bus.turn_active = 1'b0;
    bus.hit_dog = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_force",    int'(bus.throw_force), 0);
    chk("rst_enable",   int'(bus.enable), 0);
    chk("rst_charging", int'(bus.charging), 0);
    chk("rst_ready",    int'(bus.ready), 0);
    rst_n = 1'b1;
    bus.turn_active = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_idle", int'(bus.ready), 1);
    bus.hit_dog = 1'b1;
    @(negedge clk);
    bus.hit_dog = 1'b0;
    repeat (2) @(negedge clk);

    // Basic throw: three ticks, latch 30, hold 20 ticks, cooldown 4.
    exp_seq = {10, 20, 30};
    press_hold(14, 30, "t1");
    cnt = 0;
    while (bus.enable && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("t1_enable_cycles", cnt, HOLD * TD);
    chk("t1_cool_force", int'(bus.throw_force), 30);
    cnt = 0;
    while (bus.throw_force != 0 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("t1_cool_cycles", cnt, CD);
    repeat (3) @(negedge clk);

    // Full ramp up and back down; release latches 10.
    exp_seq = {10, 20, 30, 40, 50, 40, 30, 20, 10};
    press_hold(38, 10, "t2");
    wait_idle("t2");
    repeat (3) @(negedge clk);

    // Hit after 5 ticks ends the throw; a press during the throw held
    // through cooldown must not start a new charge.
    exp_seq = {10};
    press_hold(6, 10, "t3");
    repeat (10) @(negedge clk);
    bus.btn = 1'b1;
    repeat (10) @(negedge clk);
    bus.hit_dog = 1'b1;
    @(negedge clk);
    bus.hit_dog = 1'b0;
    chk("t3_hit_enable", int'(bus.enable), 0);
    chk("t3_hit_force", int'(bus.throw_force), 10);
    repeat (12) @(negedge clk);
    chk("t3_no_recharge", int'(bus.charging), 0);
    chk("t3_no_rethrow", int'(bus.enable), 0);
    bus.btn = 1'b0;
    repeat (6) @(negedge clk);

    // Turn lost at force 20 during charge; then press without the turn.
    bus.btn = 1'b1;
    repeat (12) @(negedge clk);
    chk("t4_force_before_drop", int'(bus.throw_force), 20);
    bus.turn_active = 1'b0;
    @(negedge clk);
    chk("t4_drop_charging", int'(bus.charging), 0);
    chk("t4_drop_force", int'(bus.throw_force), 0);
    bus.btn = 1'b0;
    repeat (5) @(negedge clk);
    bus.btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_no_turn_charging", int'(bus.charging), 0);
    chk("t4_no_turn_enable", int'(bus.enable), 0);
    bus.btn = 1'b0;
    repeat (5) @(negedge clk);
    bus.turn_active = 1'b1;
    repeat (2) @(negedge clk);

    // Release on the same cycle as a tick at 30 going up latches 30.
    exp_seq = {10, 20, 30};
    press_hold(16, 30, "t5");

    // Asynchronous reset in the middle of the throw.
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_enable", int'(bus.enable), 0);
    chk("t5_rst_force", int'(bus.throw_force), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Normal behaviour after reset.
    exp_seq = {10, 20};
    press_hold(10, 20, "t6");
    wait_idle("t6");
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/throw_force_meter.md
THROW_FORCE_METER -- requirements
Module: throw_force_meter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 65000, clk cycles per meter tick (1 ms at 65 MHz).
REQ-002 SHALL have parameter FORCE_STEP, default 10, force increment/decrement per tick.
REQ-003 SHALL have parameter FORCE_MAX, default 1000, ramp ceiling (must be < 1024).
REQ-004 SHALL have parameter HOLD_TICKS, default 3000, ticks enable is held per throw.
REQ-005 SHALL have parameter COOLDOWN_CYCLES, default 4, clk cycles enable stays low before re-arm.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port btn, input, 1, raw mouse left button, asynchronous to clk.
REQ-009 SHALL have port turn_active, input, 1, high while this player may throw.
REQ-010 SHALL have port hit_dog, input, 1, one-cycle hit pulse from the throw controller.
REQ-011 SHALL have port throw_force, output, 10, live meter value while charging, latched value while throwing.
REQ-012 SHALL have port enable, output, 1, throw start/hold level to the throw controller.
REQ-013 SHALL have port charging, output, 1, high in CHARGE (power-bar display).
REQ-014 SHALL have port ready, output, 1, high when state is IDLE and turn_active is high.

Function
REQ-015 SHALL pass btn through a 2-FF synchronizer (btn_s), then a 1-FF delay (btn_d); press = btn_s & !btn_d, release = !btn_s & btn_d.
REQ-016 SHALL implement states IDLE, CHARGE, THROW, COOLDOWN; all outputs registered.
REQ-017 IDLE: throw_force = 0, enable = 0; press while turn_active -> CHARGE next cycle; press while !turn_active ignored.
REQ-018 CHARGE entry SHALL clear the tick counter, set throw_force = 0, and set direction up; the first tick occurs TICK_DIV cycles after entry.
REQ-019 CHARGE, on tick, direction up: if throw_force + FORCE_STEP >= FORCE_MAX then throw_force = FORCE_MAX and direction down, else add FORCE_STEP.
REQ-020 CHARGE, on tick, direction down: if throw_force <= FORCE_STEP then throw_force = 0 and direction up, else subtract FORCE_STEP.
REQ-021 Ramp arithmetic SHALL be done in at least 11 bits so the value never wraps; throw_force is always within 0..FORCE_MAX.
REQ-022 CHARGE, on release: go to THROW, freeze throw_force, assert enable the next cycle, and clear the tick and hold counters.
REQ-023 If release and tick occur in the same cycle, release wins and the pre-tick force is latched.
REQ-024 If turn_active falls during CHARGE: go to IDLE, throw_force = 0, enable stays 0.
REQ-025 THROW: enable = 1 and throw_force is constant; the hold counter increments per tick.
REQ-026 THROW SHALL exit to COOLDOWN when the hold count reaches HOLD_TICKS or when hit_dog = 1, whichever comes first; enable = 0 from the next cycle.
REQ-027 If hit_dog and hold expiry coincide, there is a single transition to COOLDOWN.
REQ-028 THROW SHALL ignore btn and turn_active.
REQ-029 COOLDOWN: enable = 0 and throw_force holds the latched value for COOLDOWN_CYCLES cycles, then go to IDLE with throw_force = 0.
REQ-030 IDLE SHALL NOT enter CHARGE from a button already held at COOLDOWN exit; a fresh press edge is required.
REQ-031 hit_dog SHALL be ignored in IDLE, CHARGE and COOLDOWN.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, throw_force = 0, enable = 0, charging = 0, ready = 0, synchronizer/edge flops = 0, all counters = 0, direction up.
REQ-033 Reset asserted mid-CHARGE or mid-THROW SHALL drop enable immediately (asynchronously); after release the block behaves as from power-up.

Verification (TICK_DIV=4, FORCE_STEP=10, FORCE_MAX=50, HOLD_TICKS=20, COOLDOWN_CYCLES=4)
REQ-034 Test: turn_active=1, press, hold 3 ticks, release -> charging high, force 10,20,30; enable=1 with throw_force=30 held for 20 ticks, then enable=0, IDLE after 4 cycles with force 0.
REQ-035 Test: hold the button for 9 ticks -> force 10,20,30,40,50,40,30,20,10, never exceeding 50 or going below 0; release latches 10.
REQ-036 Test: pulse hit_dog 5 ticks into THROW -> enable low the next cycle, COOLDOWN, then IDLE; no second throw without a new press.
REQ-037 Test: drop turn_active at force 20 during CHARGE -> IDLE, force 0, enable never asserted; press with turn_active=0 -> no response.
REQ-038 Test: release coincident with a tick at force 30 (up) -> latched 30; rst_n low mid-THROW -> enable and throw_force 0 immediately.
